// File: rtl/sobel_filter.sv
// -----------------------------------------------------------------------------
// sobel_filter
//
// Stage-2 of the edge-detect pipeline. Pops a raster-order 8-bit grayscale
// stream from an upstream first-word-fall-through FIFO, applies a 3x3 Sobel
// operator over a window built from two line buffers, and pushes one 8-bit
// magnitude per input pixel into a downstream FIFO. Pixels on the frame border
// produce 0. Frames run back to back with no reconfiguration.
//
// Parameters
//   WIDTH   pixels per row (>= 3)
//   HEIGHT  rows per frame (>= 3)
//
// Ports
//   clock      single clock, rising edge
//   reset      synchronous, active-high
//   in_rd_en   pop request to upstream FIFO
//   in_dout    upstream FIFO head (valid while in_empty = 0)
//   in_empty   upstream FIFO empty
//   out_wr_en  push request to downstream FIFO
//   out_din    Sobel magnitude
//   out_full   downstream FIFO full
// -----------------------------------------------------------------------------
module sobel_filter #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_rd_en,
    input  logic [7:0] in_dout,
    input  logic       in_empty,
    output logic       out_wr_en,
    output logic [7:0] out_din,
    input  logic       out_full
);

    localparam int SR_LEN = 2 * WIDTH + 2;
    localparam int CNT_W  = $clog2(WIDTH * HEIGHT);
    localparam int COL_W  = $clog2(WIDTH);
    localparam int ROW_W  = $clog2(HEIGHT);

    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] IN_LAST   = CNT_W'(WIDTH * HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [COL_W-1:0] out_col_q, out_col_d;

    // sr_q[0] is the most recently accepted pixel; higher indices are older.
    logic [7:0] sr_q [0:SR_LEN-1];
    logic [7:0] sr_d [0:SR_LEN-1];

    logic [7:0] mag_s;
    logic       border_s;

    // |(a + 2b + c) - (d + 2e + f)| computed as an unsigned difference of the
    // two non-negative halves, which equals the absolute value of the signed
    // 12-bit gradient without any sign handling.
    function automatic logic [11:0] grad_abs(
        input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
        input logic [7:0] d, input logic [7:0] e, input logic [7:0] f
    );
        logic [11:0] pos;
        logic [11:0] neg;
        pos = {4'd0, a} + {3'd0, b, 1'b0} + {4'd0, c};
        neg = {4'd0, d} + {3'd0, e, 1'b0} + {4'd0, f};
        return (pos >= neg) ? (pos - neg) : (neg - pos);
    endfunction

    // (|gx| + |gy|) >> 1, saturated to 8 bits.
    function automatic logic [7:0] sobel_mag(
        input logic [7:0] p00, input logic [7:0] p01, input logic [7:0] p02,
        input logic [7:0] p10, input logic [7:0] p12,
        input logic [7:0] p20, input logic [7:0] p21, input logic [7:0] p22
    );
        logic [11:0] ax;
        logic [11:0] ay;
        logic [12:0] sum;
        logic [11:0] half;
        ax   = grad_abs(p02, p12, p22, p00, p10, p20);
        ay   = grad_abs(p20, p21, p22, p00, p01, p02);
        sum  = {1'b0, ax} + {1'b0, ay};
        half = sum[12:1];
        return (half > 12'd255) ? 8'd255 : half[7:0];
    endfunction

    // Window taps: the FIFO head is pixel k+WIDTH+1, so the window centred on
    // pixel k spans the head plus fixed offsets into the shift register.
    always_comb begin
        mag_s = sobel_mag(sr_q[2*WIDTH+1], sr_q[2*WIDTH], sr_q[2*WIDTH-1],
                          sr_q[WIDTH+1],                  sr_q[WIDTH-1],
                          sr_q[1],         sr_q[0],       in_dout);
    end

    // Border detection on the position of the next output pixel.
    always_comb begin
        border_s = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                   (out_col_q == '0) || (out_col_q == COL_LAST);
    end

    // Output data: forced to 0 during reset and on the border.
    always_comb begin
        if (reset || border_s) begin
            out_din = 8'd0;
        end else begin
            out_din = mag_s;
        end
    end

    // Handshake, next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;

        case (state_q)
            S_FILL: begin
                in_rd_en = !in_empty;
            end
            S_RUN: begin
                // Input and output move together so the window stays aligned.
                in_rd_en  = !in_empty && !out_full;
                out_wr_en = !in_empty && !out_full;
            end
            S_FLUSH: begin
                out_wr_en = !out_full;
            end
            default: begin
                in_rd_en  = 1'b0;
                out_wr_en = 1'b0;
            end
        endcase

        if (reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end else begin
            in_rd_en  = in_rd_en;
            out_wr_en = out_wr_en;
        end

        if (in_rd_en) begin
            if (in_cnt_q == IN_LAST) begin
                in_cnt_d = '0;
            end else begin
                in_cnt_d = in_cnt_q + CNT_W'(1);
            end
        end else begin
            in_cnt_d = in_cnt_q;
        end

        if (out_wr_en) begin
            if (out_col_q == COL_LAST) begin
                out_col_d = '0;
                if (out_row_q == ROW_LAST) begin
                    out_row_d = '0;
                end else begin
                    out_row_d = out_row_q + ROW_W'(1);
                end
            end else begin
                out_col_d = out_col_q + COL_W'(1);
                out_row_d = out_row_q;
            end
        end else begin
            out_col_d = out_col_q;
            out_row_d = out_row_q;
        end

        case (state_q)
            S_FILL: begin
                if (in_rd_en && (in_cnt_q == FILL_LAST)) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_RUN: begin
                if (in_rd_en && (in_cnt_q == IN_LAST)) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FLUSH: begin
                if (out_wr_en && (out_row_q == ROW_LAST) && (out_col_q == COL_LAST)) begin
                    state_d = S_FILL;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Shift register next value: shift by one on every accepted pixel.
    always_comb begin
        sr_d = sr_q;
        if (in_rd_en) begin
            sr_d[0] = in_dout;
            for (int i = 1; i < SR_LEN; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end else begin
            sr_d = sr_q;
        end
    end

    // Control state and counters, synchronously reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_FILL;
            in_cnt_q  <= '0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

    // Line-buffer storage; contents after reset are irrelevant because the
    // fill phase rewrites every tap before it is used for a non-border output.
    always_ff @(posedge clock) begin
        sr_q <= sr_d;
    end

endmodule

// File: tb/tb_sobel_filter.sv
// -----------------------------------------------------------------------------
// tb_sobel_filter
//
// Self-checking bench for sobel_filter at WIDTH=8, HEIGHT=6. An upstream FWFT
// FIFO is modelled by a pixel queue; expected magnitudes come from a direct
// Sobel reference on the full image and are queued when a frame is enqueued,
// then popped as the DUT pushes outputs.
// -----------------------------------------------------------------------------
module tb_sobel_filter;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic       clock;
    logic       reset;
    logic       in_rd_en;
    logic [7:0] in_dout;
    logic       in_empty;
    logic       out_wr_en;
    logic [7:0] out_din;
    logic       out_full;

    int n_checks;
    int n_bad;
    int out_seen;
    int acc_cnt;

    logic [7:0] in_q [$];
    logic [7:0] sb_q [$];
    int img [0:N-1];

    sobel_filter #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .out_wr_en (out_wr_en),
        .out_din   (out_din),
        .out_full  (out_full)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    function automatic int px(int r, int c);
        return img[r*W + c];
    endfunction

    function automatic int ref_pix(int r, int c);
        int gx, gy, ax, ay, m;
        if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
        gx = (px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1))
           - (px(r-1,c-1) + 2*px(r,c-1) + px(r+1,c-1));
        gy = (px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1))
           - (px(r-1,c-1) + 2*px(r-1,c) + px(r-1,c+1));
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        m  = (ax + ay) / 2;
        return (m > 255) ? 255 : m;
    endfunction

    // kind 0: constant 100, 1: vertical step, 2: single pixel 40 at (2,2)
    task automatic enqueue_frame(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (kind)
                    0:       img[r*W+c] = 100;
                    1:       img[r*W+c] = (c >= 4) ? 255 : 0;
                    default: img[r*W+c] = (r == 2 && c == 2) ? 40 : 0;
                endcase
            end
        end
        for (int i = 0; i < N; i++) in_q.push_back(8'(img[i]));
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                sb_q.push_back(8'(ref_pix(r, c)));
            end
        end
    endtask

    // One clock: drive inputs, sample at the falling edge, commit pops.
    task automatic do_cycle(input bit stall);
        logic [7:0] exp_v;
        in_empty = (in_q.size() == 0) || (stall && ($urandom_range(0, 1) == 1));
        in_dout  = (in_q.size() != 0) ? in_q[0] : 8'd0;
        out_full = stall && ($urandom_range(0, 1) == 1);
        @(negedge clock);
        check_eq("rd_while_empty", int'(in_rd_en & in_empty), 0);
        check_eq("wr_while_full", int'(out_wr_en & out_full), 0);
        if (out_wr_en) begin
            out_seen++;
            if (sb_q.size() == 0) begin
                check_eq("extra_output", 1, 0);
            end else begin
                exp_v = sb_q.pop_front();
                check_eq("pixel", int'(out_din), int'(exp_v));
            end
        end
        if (in_rd_en) begin
            acc_cnt++;
            void'(in_q.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_drain(input bit stall, input int expect_outs);
        int n;
        n = 0;
        out_seen = 0;
        while ((sb_q.size() != 0 || in_q.size() != 0) && n < 2000) begin
            do_cycle(stall);
            n++;
        end
        check_eq("drain_left", sb_q.size(), 0);
        check_eq("out_count", out_seen, expect_outs);
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        out_seen = 0;
        acc_cnt  = 0;
        reset    = 1'b1;
        in_dout  = 8'd55;
        in_empty = 1'b0;
        out_full = 1'b0;

        // Reset: outputs quiet even with data available.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_rd_en", int'(in_rd_en), 0);
        check_eq("rst_wr_en", int'(out_wr_en), 0);
        check_eq("rst_dout", int'(out_din), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        enqueue_frame(0);
        run_drain(1'b0, N);
        enqueue_frame(1);
        run_drain(1'b0, N);
        enqueue_frame(2);
        run_drain(1'b0, N);
        enqueue_frame(1);
        run_drain(1'b1, N);
        enqueue_frame(1);
        enqueue_frame(2);
        run_drain(1'b0, 2*N);

        // Abort a frame with reset after 20 accepts.
        enqueue_frame(1);
        acc_cnt = 0;
        while (acc_cnt < 20 && in_q.size() != 0) do_cycle(1'b0);
        check_eq("pre_reset_accepts", acc_cnt, 20);
        reset    = 1'b1;
        in_empty = 1'b0;
        in_dout  = (in_q.size() != 0) ? in_q[0] : 8'd0;
        out_full = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_rd_en", int'(in_rd_en), 0);
        check_eq("mid_rst_wr_en", int'(out_wr_en), 0);
        check_eq("mid_rst_dout", int'(out_din), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        in_q.delete();
        sb_q.delete();
        enqueue_frame(1);
        run_drain(1'b0, N);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
